ascon_dec_loader: RTL and testbench

Byte-serial front end for the Decryption core. It collects key, nonce, associated data, ciphertext and the received tag from an 8-bit valid/ready stream, then drives the core's parallel inputs and `decryption_start`. It compares the computed tag against the received tag in constant time and releases plaintext only on authentication success, through an output valid/ready handshake.

---
 rtl/ascon_pkg.sv | 32 +++
 rtl/ascon_tag_compare.sv | 12 +
 rtl/ascon_dec_loader.sv | 125 ++++++++++++
 tb/tb_ascon_dec_loader.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ascon_pkg.sv
// Shared types and stream layout for the Ascon decryption loader.
// Field byte boundaries are derived from the AD/CT lengths in bits.
package ascon_pkg;

  typedef enum logic [1:0] {
    LOAD   = 2'd0,
    RUN    = 2'd1,
    RESULT = 2'd2
  } state_t;

  localparam int unsigned KEY_BYTES   = 16;
  localparam int unsigned NONCE_BYTES = 16;
  localparam int unsigned TAG_BYTES   = 16;

  // First byte index of the associated-data slot.
  function automatic int unsigned ad_start();
    return KEY_BYTES + NONCE_BYTES;
  endfunction

  function automatic int unsigned ct_start(input int unsigned l);
    return ad_start() + l / 8;
  endfunction

  function automatic int unsigned tag_start(input int unsigned l, input int unsigned y);
    return ct_start(l) + y / 8;
  endfunction

  function automatic int unsigned total_bytes(input int unsigned l, input int unsigned y);
    return tag_start(l, y) + TAG_BYTES;
  endfunction

endpackage

// File: rtl/ascon_tag_compare.sv
// Constant-time tag equality: full-width XOR then OR-reduce, no early exit.
module ascon_tag_compare
  import ascon_pkg::*;
(
  input  logic [TAG_BYTES*8-1:0] a,
  input  logic [TAG_BYTES*8-1:0] b,
  output logic                   match
);

  assign match = ~|(a ^ b);

endmodule

// File: rtl/ascon_dec_loader.sv
// Byte-serial loader for the Ascon decryption core: collects key/nonce/AD/CT/tag,
// launches the core, and releases plaintext only after a constant-time tag check.
module ascon_dec_loader
  import ascon_pkg::*;
#(
  parameter int unsigned l = 40,
  parameter int unsigned y = 40,
  localparam int unsigned AD_W = (l == 0) ? 1 : l,
  localparam int unsigned CT_W = (y == 0) ? 1 : y
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [7:0]      in_data,
  input  logic            in_valid,
  output logic            in_ready,
  output logic [127:0]    key,
  output logic [127:0]    nonce,
  output logic [AD_W-1:0] associated_data,
  output logic [CT_W-1:0] cipher_text,
  output logic            decryption_start,
  input  logic [CT_W-1:0] dec_plain_text,
  input  logic [127:0]    dec_tag,
  input  logic            decryption_ready,
  output logic [CT_W-1:0] out_plain_text,
  output logic            out_auth_ok,
  output logic            out_valid,
  input  logic            out_ready
);

  localparam int unsigned N       = total_bytes(l, y);
  localparam int unsigned BC_W    = $clog2(N);
  localparam int unsigned KEY_END = KEY_BYTES;
  localparam int unsigned AD_BEG  = ad_start();
  localparam int unsigned CT_BEG  = ct_start(l);
  localparam int unsigned TAG_BEG = tag_start(l, y);

  state_t          state_q;
  state_t          state_d;
  logic [BC_W-1:0] bc;
  logic [127:0]    rx_tag;
  logic            accept;
  logic            last_byte;
  logic            capture;
  logic            take_result;
  logic            tag_match;

  ascon_tag_compare u_tag_compare (
    .a     (dec_tag),
    .b     (rx_tag),
    .match (tag_match)
  );

  assign last_byte = (bc == BC_W'(N - 1));

  always_ff @(posedge clk) begin
    if (rst) state_q <= LOAD;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    accept      = 1'b0;
    capture     = 1'b0;
    take_result = 1'b0;
    unique case (state_q)
      LOAD: begin
        accept = in_valid && in_ready;
        if (accept && last_byte) state_d = RUN;
      end
      RUN: begin
        capture = decryption_ready;
        if (decryption_ready) state_d = RESULT;
      end
      RESULT: begin
        take_result = out_ready;
        if (out_ready) state_d = LOAD;
      end
      default: state_d = LOAD;
    endcase
  end

  // Handshake/launch flags are registered copies of the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      in_ready         <= 1'b0;
      decryption_start <= 1'b0;
      out_valid        <= 1'b0;
    end else begin
      in_ready         <= (state_d == LOAD);
      decryption_start <= (state_d == RUN);
      out_valid        <= (state_d == RESULT);
    end
  end

  // Fields shift in MSB-first; an empty AD or CT slot has equal bounds and is skipped.
  always_ff @(posedge clk) begin
    if (rst) begin
      bc              <= '0;
      key             <= '0;
      nonce           <= '0;
      associated_data <= '0;
      cipher_text     <= '0;
      rx_tag          <= '0;
    end else if (accept) begin
      bc <= last_byte ? '0 : bc + 1'b1;
      if (bc < BC_W'(KEY_END))      key             <= {key[119:0], in_data};
      else if (bc < BC_W'(AD_BEG))  nonce           <= {nonce[119:0], in_data};
      else if (bc < BC_W'(CT_BEG))  associated_data <= AD_W'({associated_data, in_data});
      else if (bc < BC_W'(TAG_BEG)) cipher_text     <= CT_W'({cipher_text, in_data});
      else                          rx_tag          <= {rx_tag[119:0], in_data};
    end
  end

  // Plaintext is gated by the tag check so a forged message never leaks.
  always_ff @(posedge clk) begin
    if (rst || take_result) begin
      out_auth_ok    <= 1'b0;
      out_plain_text <= '0;
    end else if (capture) begin
      out_auth_ok    <= tag_match;
      out_plain_text <= tag_match ? dec_plain_text : '0;
    end
  end

endmodule

// File: tb/tb_ascon_dec_loader.sv
// Bench for ascon_dec_loader: three builds (l/y = 40/40, 0/40, 40/0), each with a
// toy stand-in core, a phase-level reference model and directed stimulus.
module tb_ascon_dec_loader;

  int checks = 0;
  int errors = 0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input int inst, input string nm, input logic [127:0] got,
                     input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL [build %0d] %s: got %h expected %h", inst, nm, got, exp);
    end
  endtask

  for (genvar g = 0; g < 3; g++) begin : g_inst
    localparam int unsigned L  = (g == 1) ? 0 : 40;
    localparam int unsigned Y  = (g == 2) ? 0 : 40;
    localparam int unsigned LB = L / 8;
    localparam int unsigned YB = Y / 8;
    localparam int unsigned NB = 48 + LB + YB;
    localparam int unsigned AW = (L == 0) ? 1 : L;
    localparam int unsigned CW = (Y == 0) ? 1 : Y;
    localparam int unsigned CORE_LAT = 8 + g;
    localparam logic [127:0] EXP_TAG = (g == 0) ? 128'h0B0C0D0E0F :
                                       (g == 1) ? 128'h0B0D0F0D0B : 128'h0001020304;
    localparam logic [CW-1:0] EXP_PT = (Y == 0) ? '0 : CW'(40'h0001020304);
    localparam logic [CW-1:0] EXP_CT = (Y == 0) ? '0 : CW'(40'h0B0D0F0D0B);

    logic          rst;
    logic [7:0]    in_data;
    logic          in_valid, in_ready;
    logic [127:0]  key, nonce, dec_tag;
    logic [AW-1:0] associated_data;
    logic [CW-1:0] cipher_text, dec_plain_text, out_plain_text;
    logic          decryption_start, decryption_ready;
    logic          out_auth_ok, out_valid, out_ready;
    logic          spur, core_rdy;
    int            lat_cnt;
    int            cyc = 0;
    bit            fin = 1'b0;

    logic [127:0]  cur_key, cur_nonce, cur_tag;
    logic [AW-1:0] cur_ad;
    logic [CW-1:0] cur_ct;
    logic [7:0]    vbytes[$];

    ascon_dec_loader #(.l(L), .y(Y)) dut (
      .clk              (clk),
      .rst              (rst),
      .in_data          (in_data),
      .in_valid         (in_valid),
      .in_ready         (in_ready),
      .key              (key),
      .nonce            (nonce),
      .associated_data  (associated_data),
      .cipher_text      (cipher_text),
      .decryption_start (decryption_start),
      .dec_plain_text   (dec_plain_text),
      .dec_tag          (dec_tag),
      .decryption_ready (decryption_ready),
      .out_plain_text   (out_plain_text),
      .out_auth_ok      (out_auth_ok),
      .out_valid        (out_valid),
      .out_ready        (out_ready)
    );

    // Stand-in core: fixed latency, ready held until start drops.
    always @(posedge clk) begin
      cyc <= cyc + 1;
      if (rst || !decryption_start) begin
        lat_cnt  <= 0;
        core_rdy <= 1'b0;
      end else if (lat_cnt == CORE_LAT) begin
        core_rdy <= 1'b1;
      end else begin
        lat_cnt <= lat_cnt + 1;
      end
    end
    assign decryption_ready = core_rdy | spur;
    assign dec_tag = key ^ nonce ^ 128'(associated_data) ^ 128'(cipher_text);
    assign dec_plain_text = (Y == 0) ? '0 : CW'(cipher_text ^ CW'(key));

    // Reference model: stream phase, byte count, and the expected result.
    int            m_phase = 0;
    int            m_cnt = 0;
    bit            m_fresh = 1'b1;
    bit            armed = 1'b0;
    logic          m_ok = 1'b0;
    logic [CW-1:0] m_pt = '0;

    initial begin : model
      logic exp_rdy;
      logic [127:0] core_tag;
      forever begin
        @(negedge clk);
        exp_rdy = (m_phase == 0) && !m_fresh;
        if (armed) begin
          chk(g, "in_ready", 128'(in_ready), 128'(exp_rdy));
          chk(g, "decryption_start", 128'(decryption_start), 128'(m_phase == 1));
          chk(g, "out_valid", 128'(out_valid), 128'(m_phase == 2));
          chk(g, "out_auth_ok", 128'(out_auth_ok), 128'((m_phase == 2) ? m_ok : 1'b0));
          chk(g, "out_plain_text", 128'(out_plain_text), 128'((m_phase == 2) ? m_pt : '0));
          if (m_phase == 1) begin
            chk(g, "key_field", key, cur_key);
            chk(g, "nonce_field", nonce, cur_nonce);
            chk(g, "ad_field", 128'(associated_data), 128'(cur_ad));
            chk(g, "ct_field", 128'(cipher_text), 128'(cur_ct));
          end
        end
        if (rst) begin
          armed   = 1'b1;
          m_phase = 0;
          m_cnt   = 0;
          m_fresh = 1'b1;
        end else begin
          m_fresh = 1'b0;
          case (m_phase)
            0: begin
              if (in_valid && exp_rdy) m_cnt++;
              if (m_cnt == int'(NB)) begin
                m_cnt   = 0;
                m_phase = 1;
              end
            end
            1: if (decryption_ready) begin
              core_tag = cur_key ^ cur_nonce ^ 128'(cur_ad) ^ 128'(cur_ct);
              m_ok     = (core_tag == cur_tag);
              m_pt     = (m_ok && Y != 0) ? CW'(cur_ct ^ CW'(cur_key)) : '0;
              m_phase  = 2;
            end
            default: if (out_ready) m_phase = 0;
          endcase
        end
      end
    end

    // Golden vector: CT = PT ^ low key bits, tag = key ^ nonce ^ AD ^ CT.
    task automatic make_vec(input int seed, input bit corrupt);
      logic [7:0]    b;
      logic [CW-1:0] pt;
      vbytes.delete();
      cur_ad = '0;
      pt     = '0;
      for (int i = 0; i < 16; i++) begin
        b = 8'(i + seed * 17);
        cur_key = {cur_key[119:0], b};
        vbytes.push_back(b);
      end
      for (int i = 0; i < 16; i++) begin
        b = 8'(i + seed * 34);
        cur_nonce = {cur_nonce[119:0], b};
        vbytes.push_back(b);
      end
      for (int i = 0; i < int'(LB); i++) begin
        b = 8'(i + seed * 3);
        cur_ad = AW'({cur_ad, b});
        vbytes.push_back(b);
      end
      for (int i = 0; i < int'(YB); i++) pt = CW'({pt, 8'(i + seed * 5)});
      cur_ct = (Y == 0) ? '0 : CW'(pt ^ CW'(cur_key));
      for (int i = 0; i < int'(YB); i++) vbytes.push_back(8'(cur_ct >> (8 * (int'(YB) - 1 - i))));
      cur_tag = cur_key ^ cur_nonce ^ 128'(cur_ad) ^ 128'(cur_ct);
      if (corrupt) cur_tag = cur_tag ^ 128'h1;
      for (int i = 0; i < 16; i++) vbytes.push_back(8'(cur_tag >> (8 * (15 - i))));
    endtask

    task automatic send_vec(input int gap, input int stop, output int t_last);
      int  i = 0;
      int  guard = 0;
      bit  acc;
      t_last = cyc;
      while (i < stop && guard < 2000) begin
        guard++;
        if (gap > 0 && $urandom_range(99) < gap) begin
          in_valid = 1'b0;
        end else begin
          in_valid = 1'b1;
          in_data  = vbytes[i];
        end
        acc = in_valid && in_ready;
        @(posedge clk); #1;
        if (acc) begin
          i++;
          t_last = cyc;
        end
      end
      in_valid = 1'b0;
      if (i < stop) chk(g, "load_timeout", 128'(i), 128'(stop));
    endtask

    task automatic wait_valid(output int t);
      int c = 0;
      while (!out_valid && c < 200) begin
        @(posedge clk); #1;
        c++;
      end
      t = cyc;
      if (!out_valid) chk(g, "result_timeout", 128'(out_valid), 128'(1));
    endtask

    task automatic check_reset(input string tag);
      chk(g, {tag, "_key"}, key, 128'(0));
      chk(g, {tag, "_nonce"}, nonce, 128'(0));
      chk(g, {tag, "_ad"}, 128'(associated_data), 128'(0));
      chk(g, {tag, "_ct"}, 128'(cipher_text), 128'(0));
      chk(g, {tag, "_pt"}, 128'(out_plain_text), 128'(0));
      chk(g, {tag, "_ok"}, 128'(out_auth_ok), 128'(0));
      chk(g, {tag, "_valid"}, 128'(out_valid), 128'(0));
      chk(g, {tag, "_start"}, 128'(decryption_start), 128'(0));
      chk(g, {tag, "_in_ready"}, 128'(in_ready), 128'(0));
    endtask

    initial begin : drive
      int t_last, t_valid, lat_pass, lat_fail, t0, c;
      rst = 1'b1; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b1; spur = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_reset("por");
      rst = 1'b0;

      // Known answer with out_ready already high.
      make_vec(0, 1'b0);
      chk(g, "kat_tag_pin", cur_tag, EXP_TAG);
      chk(g, "kat_ct_pin", 128'(cur_ct), 128'(EXP_CT));
      chk(g, "kat_len", 128'(vbytes.size()), 128'(NB));
      send_vec(0, int'(NB), t_last);
      wait_valid(t_valid);
      lat_pass = t_valid - t_last;
      chk(g, "kat_ok", 128'(out_auth_ok), 128'(1));
      chk(g, "kat_pt", 128'(out_plain_text), 128'(EXP_PT));
      @(posedge clk); #1;

      // Last tag byte flipped: rejected, zero plaintext, same latency.
      make_vec(0, 1'b1);
      send_vec(0, int'(NB), t_last);
      wait_valid(t_valid);
      lat_fail = t_valid - t_last;
      chk(g, "bad_tag_ok", 128'(out_auth_ok), 128'(0));
      chk(g, "bad_tag_pt", 128'(out_plain_text), 128'(0));
      chk(g, "equal_latency", 128'(lat_fail), 128'(lat_pass));
      @(posedge clk); #1;

      // Stray core ready in LOAD, 30% input gaps, junk bytes in RUN, result held 20 cycles.
      make_vec(1, 1'b0);
      out_ready = 1'b0;
      spur = 1'b1;
      @(posedge clk); #1;
      spur = 1'b0;
      send_vec(30, int'(NB), t_last);
      in_valid = 1'b1;
      in_data  = 8'hEE;
      wait_valid(t_valid);
      in_valid = 1'b0;
      repeat (20) @(posedge clk);
      #1;
      chk(g, "hold_ok", 128'(out_auth_ok), 128'(1));
      out_ready = 1'b1;
      @(posedge clk); #1;
      chk(g, "hold_released", 128'(out_valid), 128'(0));

      // Reset mid-load, then reset mid-run.
      make_vec(2, 1'b0);
      send_vec(0, 20, t_last);
      rst = 1'b1;
      @(posedge clk); #1;
      check_reset("rst_load");
      rst = 1'b0;
      send_vec(0, int'(NB), t_last);
      c = 0;
      while (!decryption_start && c < 20) begin
        @(posedge clk); #1;
        c++;
      end
      chk(g, "run_entered", 128'(decryption_start), 128'(1));
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      check_reset("rst_run");
      rst = 1'b0;

      // Clean vector after the resets.
      send_vec(0, int'(NB), t_last);
      wait_valid(t_valid);
      chk(g, "post_rst_ok", 128'(out_auth_ok), 128'(1));
      @(posedge clk); #1;

      // Back-to-back with out_ready held high.
      make_vec(3, 1'b0);
      send_vec(0, int'(NB), t_last);
      wait_valid(t0);
      chk(g, "b2b_first_ok", 128'(out_auth_ok), 128'(1));
      make_vec(4, 1'b0);
      send_vec(0, int'(NB), t_last);
      c = 0;
      while (!decryption_start && c < 20) begin
        @(posedge clk); #1;
        c++;
      end
      chk(g, "b2b_start_gap", 128'((cyc - t0) >= 48 && decryption_start), 128'(1));
      wait_valid(t_valid);
      chk(g, "b2b_second_ok", 128'(out_auth_ok), 128'(1));
      @(posedge clk); #1;
      fin = 1'b1;
    end
  end

  initial begin : watchdog
    for (int c = 0; c < 20000; c++) begin
      if (g_inst[0].fin && g_inst[1].fin && g_inst[2].fin) break;
      @(posedge clk);
    end
    if (!(g_inst[0].fin && g_inst[1].fin && g_inst[2].fin)) begin
      checks++;
      errors++;
      $display("FAIL watchdog: drivers unfinished %0b%0b%0b", g_inst[2].fin, g_inst[1].fin,
               g_inst[0].fin);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
